// File: rtl/button_pkg.sv
// Shared constants and types for the push-button input peripheral.
//   NUM_BTN     : number of button channels on this bus map
//   ADDR_*      : register select values on the 2-bit peripheral address
//   btn_vec_t   : one bit per button channel
package button_pkg;

   localparam int NUM_BTN = 4;

   localparam logic [1:0] ADDR_LEVEL = 2'd0;
   localparam logic [1:0] ADDR_EVENT = 2'd1;
   localparam logic [1:0] ADDR_MASK  = 2'd2;

   typedef logic [NUM_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, stable level flop.
//   clk, reset : system clock, async active-high reset
//   btn        : raw pin, active-low, asynchronous to clk
//   level      : debounced level, 1 = pressed
//   press      : high for the one cycle whose closing edge accepts a press
module btn_debounce #(
   parameter int DEBOUNCE_COUNT = 48000,
   parameter int CNT_W          = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press
);

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic             s;
   logic             at_tc;
   logic [CNT_W-1:0] cnt;

   assign s     = ~sync2;
   assign at_tc = (cnt == CNT_W'(DEBOUNCE_COUNT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         // any agreeing cycle restarts the count
         if (s == stable) begin
            cnt <= '0;
         end else if (at_tc) begin
            stable <= s;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign level = stable;
   // decoded from flops only, so the event register sets on the same edge stable rises
   assign press = s & ~stable & at_tc;

endmodule

// File: rtl/button_reader.sv
// Memory-mapped push-button reader on the 8-bit peripheral bus.
//   clk, reset          : system clock, async active-high reset
//   readEnable          : read strobe; readData valid the following cycle
//   writeEnable         : write strobe
//   addr                : 0 LEVEL (RO), 1 EVENT (W1C, clear-on-read), 2 MASK (RW), 3 reads 0
//   writeData           : write data
//   readData            : registered read data, holds between reads
//   irq                 : high while any unmasked event is pending
//   btn1..btn4          : raw active-low button pins
module button_reader
   import button_pkg::*;
#(
   parameter int DEBOUNCE_COUNT = 48000,
   parameter int CNT_W          = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       readEnable,
   input  logic       writeEnable,
   input  logic [1:0] addr,
   input  logic [7:0] writeData,
   output logic [7:0] readData,
   output logic       irq,
   input  logic       btn1,
   input  logic       btn2,
   input  logic       btn3,
   input  logic       btn4
);

   btn_vec_t btn_raw;
   btn_vec_t level;
   btn_vec_t press;
   btn_vec_t event_q;
   btn_vec_t mask_q;
   btn_vec_t clr_rd;
   btn_vec_t clr_wr;
   logic     unused_wdata_hi;

   assign btn_raw         = {btn4, btn3, btn2, btn1};
   assign unused_wdata_hi = ^writeData[7:4];

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_debounce #(
         .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
         .CNT_W          (CNT_W)
      ) u_db (
         .clk   (clk),
         .reset (reset),
         .btn   (btn_raw[i]),
         .level (level[i]),
         .press (press[i])
      );
   end

   // clear-on-read drops exactly the bits being returned
   assign clr_rd = (readEnable  && addr == ADDR_EVENT) ? event_q : '0;
   assign clr_wr = (writeEnable && addr == ADDR_EVENT) ? writeData[NUM_BTN-1:0] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         event_q  <= '0;
         mask_q   <= '0;
         readData <= 8'h00;
      end else begin
         // press ORed in last: a set racing a clear keeps the bit
         event_q <= (event_q & ~(clr_rd | clr_wr)) | press;
         if (writeEnable && addr == ADDR_MASK)
            mask_q <= writeData[NUM_BTN-1:0];
         if (readEnable) begin
            case (addr)
               ADDR_LEVEL: readData <= {4'h0, level};
               ADDR_EVENT: readData <= {4'h0, event_q};
               ADDR_MASK:  readData <= {4'h0, mask_q};
               default:    readData <= 8'h00;
            endcase
         end
      end
   end

   assign irq = |(event_q & mask_q);

endmodule

// File: tb/tb_button_reader.sv
module tb_button_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       readEnable;
   logic       writeEnable;
   logic [1:0] addr;
   logic [7:0] writeData;
   logic [7:0] readData;
   logic       irq;
   logic       btn1, btn2, btn3, btn4;

   int errors = 0;
   int checks = 0;

   button_reader #(.DEBOUNCE_COUNT(4), .CNT_W(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .readEnable  (readEnable),
      .writeEnable (writeEnable),
      .addr        (addr),
      .writeData   (writeData),
      .readData    (readData),
      .irq         (irq),
      .btn1        (btn1),
      .btn2        (btn2),
      .btn3        (btn3),
      .btn4        (btn4)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
      readEnable = 1'b1;
      addr       = a;
      tick();
      readEnable = 1'b0;
      chk(tag, readData, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      writeEnable = 1'b1;
      addr        = a;
      writeData   = d;
      tick();
      writeEnable = 1'b0;
   endtask

   initial begin
      reset = 1'b1; readEnable = 1'b0; writeEnable = 1'b0;
      addr = 2'd0; writeData = 8'h00;
      btn1 = 1'b1; btn2 = 1'b1; btn3 = 1'b1; btn4 = 1'b1;
      tick(3);
      chk("reset_rdata", readData, 8'h00);
      chk("reset_irq", {7'b0, irq}, 8'h00);
      reset = 1'b0;
      tick(2);

      // 1: post-reset register reads
      rd(2'd0, 8'h00, "t1_level");
      rd(2'd1, 8'h00, "t1_event");
      rd(2'd2, 8'h00, "t1_mask");
      chk("t1_irq", {7'b0, irq}, 8'h00);

      // 2: btn1 press, acceptance on the 6th edge after the change
      btn1 = 1'b0;
      tick(5);
      readEnable = 1'b1; addr = 2'd0;
      tick();
      readEnable = 1'b0;
      chk("t2_level_edge6_pre", readData, 8'h00);
      rd(2'd0, 8'h01, "t2_level");
      rd(2'd1, 8'h01, "t2_event");
      rd(2'd1, 8'h00, "t2_event_cleared");
      btn1 = 1'b1;
      tick(8);
      rd(2'd0, 8'h00, "t2_level_released");
      rd(2'd1, 8'h00, "t2_release_no_event");

      // 3: 3-cycle glitch on btn2 is rejected
      btn2 = 1'b0;
      tick(3);
      btn2 = 1'b1;
      tick(6);
      rd(2'd0, 8'h00, "t3_level");
      rd(2'd1, 8'h00, "t3_event");

      // 4: masked interrupt and write-1-to-clear
      wr(2'd2, 8'h04);
      btn3 = 1'b0;
      tick(5);
      chk("t4_irq_early", {7'b0, irq}, 8'h00);
      tick();
      chk("t4_irq_set", {7'b0, irq}, 8'h01);
      wr(2'd1, 8'h04);
      chk("t4_irq_clr", {7'b0, irq}, 8'h00);
      rd(2'd2, 8'h04, "t4_mask");
      tick(2);
      chk("t4_rdata_hold", readData, 8'h04);
      rd(2'd3, 8'h00, "t4_addr3");
      btn3 = 1'b1;
      tick(8);

      // 5: clear-on-read on the same edge btn4 is accepted; set wins
      btn4 = 1'b0;
      tick(5);
      readEnable = 1'b1; addr = 2'd1;
      tick();
      readEnable = 1'b0;
      chk("t5_event_same_edge", readData, 8'h00);
      chk("t5_irq_masked", {7'b0, irq}, 8'h00);
      rd(2'd1, 8'h08, "t5_event_kept");
      btn4 = 1'b1;
      tick(8);

      // 6: reset mid-count discards in-flight debounce
      btn1 = 1'b0;
      tick(3);
      reset = 1'b1;
      tick();
      chk("t6_rdata_reset", readData, 8'h00);
      chk("t6_irq_reset", {7'b0, irq}, 8'h00);
      reset = 1'b0;
      wr(2'd2, 8'h01);
      tick(4);
      chk("t6_irq_early", {7'b0, irq}, 8'h00);
      readEnable = 1'b1; addr = 2'd0;
      tick();
      readEnable = 1'b0;
      chk("t6_level_edge6_pre", readData, 8'h00);
      chk("t6_irq_set", {7'b0, irq}, 8'h01);
      rd(2'd0, 8'h01, "t6_level");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
